// File: rtl/pause_ctl_pkg.sv
// Shared types and constants for the pause/dim controller.
// ms_cycles() converts a clock rate in MHz into clocks per millisecond.
package pause_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, FADE, HOLD} pause_state_e;

   localparam int OPT_OSD = 0;
   localparam int OPT_DIM = 1;

   // A rate of 0 means one clock per millisecond, so fade timing can be exercised in short runs.
   function automatic int ms_cycles(input int clkspd);
      return (clkspd < 1) ? 1 : clkspd * 1000;
   endfunction

endpackage

// File: rtl/pause_ctl_rgb_dimmer.sv
// Registered per-channel right shifter: each colour field of {r,g,b} is
// shifted by dim_level on its own, zero-filled, with one clock of latency.
module rgb_dimmer #(
   parameter int RW        = 3,
   parameter int GW        = 3,
   parameter int BW        = 2,
   parameter int DIM_SHIFT = 1
) (
   input  logic                          clk_sys,
   input  logic                          reset,
   input  logic [$clog2(DIM_SHIFT+1)-1:0] dim_level,
   input  logic [RW-1:0]                 r,
   input  logic [GW-1:0]                 g,
   input  logic [BW-1:0]                 b,
   output logic [RW+GW+BW-1:0]           rgb_out
);

   logic [RW+GW+BW-1:0] rgb_d;
   logic [RW+GW+BW-1:0] rgb_q;

   always_comb begin
      rgb_d = {r >> dim_level, g >> dim_level, b >> dim_level};
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         rgb_q <= '0;
      end else begin
         rgb_q <= rgb_d;
      end
   end

   assign rgb_out = rgb_q;

endmodule

// File: rtl/pause_ctl.sv
// Merges user/engine/OSD pause sources into a registered pause_cpu and fades
// the video in DIM_SHIFT steps once the core has been paused for DIM_SEC seconds.
module pause_ctl
   import pause_pkg::*;
#(
   parameter int RW        = 3,
   parameter int GW        = 3,
   parameter int BW        = 2,
   parameter int CLKSPD    = 12,
   parameter int NREQ      = 2,
   parameter int DIM_SEC   = 10,
   parameter int DIM_SHIFT = 1,
   parameter int STEP_MS   = 125
) (
   input  logic                           clk_sys,
   input  logic                           reset,
   input  logic                           user_button,
   input  logic [NREQ-1:0]                pause_request,
   input  logic                           OSD_STATUS,
   input  logic [1:0]                     options,
   input  logic [RW-1:0]                  r,
   input  logic [GW-1:0]                  g,
   input  logic [BW-1:0]                  b,
   output logic [RW+GW+BW-1:0]            rgb_out,
   output logic                           pause_cpu,
   output logic [$clog2(DIM_SHIFT+1)-1:0] dim_level
);

   localparam int PRE_MAX = ms_cycles(CLKSPD) - 1;
   localparam int PW      = (PRE_MAX > 0) ? $clog2(PRE_MAX + 1) : 1;
   localparam int WAIT_MS = DIM_SEC * 1000;
   localparam int MS_MAX  = (WAIT_MS > STEP_MS) ? WAIT_MS : STEP_MS;
   localparam int MW      = $clog2(MS_MAX + 1);
   localparam int DLW     = $clog2(DIM_SHIFT + 1);
   localparam int MIN_W   = (RW < GW) ? ((RW < BW) ? RW : BW) : ((GW < BW) ? GW : BW);

   localparam logic [PW-1:0]  PRE_MAX_C = PW'(PRE_MAX);
   localparam logic [MW-1:0]  WAIT_C    = MW'(WAIT_MS);
   localparam logic [MW-1:0]  STEP_C    = MW'(STEP_MS);
   localparam logic [MW-1:0]  MS_MAX_C  = MW'(MS_MAX);
   localparam logic [DLW-1:0] DIM_MAX_C = DLW'(DIM_SHIFT);

   generate
      if (DIM_SHIFT < 1 || DIM_SHIFT > MIN_W) begin : g_bad_dim_shift
         $error("pause_ctl: DIM_SHIFT must lie in 1..min(RW,GW,BW)");
      end
      if (NREQ < 1 || DIM_SEC < 1 || STEP_MS < 1) begin : g_bad_counts
         $error("pause_ctl: NREQ, DIM_SEC and STEP_MS must be at least 1");
      end
   endgenerate

   logic           btn_q, btn_d;
   logic           toggle_q, toggle_d;
   logic           pause_q, pause_d;
   pause_state_e   state_q, state_d;
   logic [PW-1:0]  pre_q, pre_d;
   logic [MW-1:0]  ms_q, ms_d;
   logic [DLW-1:0] dim_q, dim_d;
   logic           tick;
   logic           dim_en;
   logic [MW-1:0]  ms_inc;

   always_comb begin
      btn_d    = user_button;
      toggle_d = toggle_q ^ (user_button & ~btn_q);
      pause_d  = toggle_q | (|pause_request) | (OSD_STATUS & options[OPT_OSD]);
      dim_en   = options[OPT_DIM];
      tick     = (pre_q == PRE_MAX_C);
      ms_inc   = (ms_q == MS_MAX_C) ? ms_q : ms_q + MW'(tick);

      state_d = state_q;
      pre_d   = pre_q;
      ms_d    = ms_q;
      dim_d   = dim_q;

      // The FSM follows the next pause value so a release clears dimming on the same edge.
      if (!pause_d) begin
         state_d = IDLE;
         pre_d   = '0;
         ms_d    = '0;
         dim_d   = '0;
      end else begin
         if (state_q == WAIT || state_q == FADE) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
         end
         case (state_q)
            IDLE: state_d = WAIT;
            WAIT: begin
               ms_d = ms_inc;
               if (dim_en && ms_inc >= WAIT_C) begin
                  state_d = FADE;
                  ms_d    = '0;
               end
            end
            FADE: begin
               if (!dim_en) begin
                  state_d = WAIT;
                  ms_d    = '0;
                  dim_d   = '0;
               end else begin
                  ms_d = ms_inc;
                  if (ms_inc >= STEP_C) begin
                     ms_d  = '0;
                     dim_d = dim_q + DLW'(1);
                     if (dim_q + DLW'(1) == DIM_MAX_C) state_d = HOLD;
                  end
               end
            end
            HOLD: begin
               if (!dim_en) begin
                  state_d = WAIT;
                  ms_d    = '0;
                  dim_d   = '0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         btn_q    <= 1'b0;
         toggle_q <= 1'b0;
         pause_q  <= 1'b0;
         state_q  <= IDLE;
         pre_q    <= '0;
         ms_q     <= '0;
         dim_q    <= '0;
      end else begin
         btn_q    <= btn_d;
         toggle_q <= toggle_d;
         pause_q  <= pause_d;
         state_q  <= state_d;
         pre_q    <= pre_d;
         ms_q     <= ms_d;
         dim_q    <= dim_d;
      end
   end

   assign pause_cpu = pause_q;
   assign dim_level = dim_q;

   rgb_dimmer #(
      .RW        (RW),
      .GW        (GW),
      .BW        (BW),
      .DIM_SHIFT (DIM_SHIFT)
   ) u_dimmer (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .dim_level (dim_q),
      .r         (r),
      .g         (g),
      .b         (b),
      .rgb_out   (rgb_out)
   );

endmodule
